// File: rtl/station_fill_aggregator_if.sv
// Poll bus shared by the fill aggregator (master) and the dropoff stations (slave).
interface station_fill_aggregator_if #(
  parameter int INT    = 31,
  parameter int ADDR_W = 4
) ();
  logic              poll_req;
  logic [ADDR_W-1:0] poll_addr;
  logic              rsp_valid;
  logic              rsp_present;
  logic [INT:0]      rsp_percentage;

  modport master (
    output poll_req, poll_addr,
    input  rsp_valid, rsp_present, rsp_percentage
  );

  modport slave (
    input  poll_req, poll_addr,
    output rsp_valid, rsp_present, rsp_percentage
  );
endinterface

// File: rtl/station_fill_aggregator.sv
// Round-robin poller that sums every station's clamped fill percentage and
// publishes the total and responder count once per round. Published values
// are held in their own registers so they stay stable during the next round.
module station_fill_aggregator #(
  parameter int MAX_STATIONS = 16,
  parameter int SLOT_TIMEOUT = 8,
  parameter int INT          = 31,
  parameter int ADDR_W       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [INT:0]             precision,
  station_fill_aggregator_if.master bus,
  output logic [INT:0]             total_percentage_stored,
  output logic [INT:0]             number_of_stations,
  output logic                     no_stations,
  output logic                     totals_valid,
  output logic                     round_done,
  output logic                     busy
);
  localparam int TW = (SLOT_TIMEOUT > 1) ? $clog2(SLOT_TIMEOUT) : 1;
  localparam int CW = $clog2(MAX_STATIONS + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_PUBLISH} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] slot_q;
  logic [TW-1:0]     timer_q;
  logic [INT:0]      sum_q;
  logic [CW-1:0]     cnt_q;
  logic [INT:0]      r_q;
  logic [INT:0]      g_q;
  logic              nos_q;
  logic              tv_q;
  logic              rd_q;
  logic              req_q;
  logic              busy_q;

  logic [INT:0]      clamped;
  logic [INT+1:0]    sum_ext;
  logic [INT:0]      sum_d;

  // Clamp the response to precision, then add with saturation at all-ones.
  always_comb begin
    clamped = (bus.rsp_percentage > precision) ? precision : bus.rsp_percentage;
    sum_ext = {1'b0, sum_q} + {1'b0, clamped};
    sum_d   = sum_ext[INT+1] ? '1 : sum_ext[INT:0];
  end

  // Poll FSM; strobes and status flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      timer_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
      g_q     <= (INT+1)'(1);
      nos_q   <= 1'b0;
      tv_q    <= 1'b0;
      rd_q    <= 1'b0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rd_q  <= 1'b0;
      req_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_REQ;
            slot_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_REQ: begin
          state_q <= S_WAIT;
          timer_q <= '0;
        end
        S_WAIT: begin
          // A strobe or the last timer tick closes the slot; later strobes
          // land in REQ/PUBLISH/IDLE where they are never looked at.
          if (bus.rsp_valid || timer_q == TW'(SLOT_TIMEOUT - 1)) begin
            if (bus.rsp_valid && bus.rsp_present) begin
              sum_q <= sum_d;
              cnt_q <= cnt_q + 1'b1;
            end
            if (slot_q == ADDR_W'(MAX_STATIONS - 1)) begin
              state_q <= S_PUBLISH;
              rd_q    <= 1'b1;
            end else begin
              slot_q  <= slot_q + 1'b1;
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_PUBLISH: begin
          // G is forced to 1 on an empty round so downstream division is safe.
          r_q     <= sum_q;
          g_q     <= (cnt_q == '0) ? (INT+1)'(1) : (INT+1)'(cnt_q);
          nos_q   <= (cnt_q == '0);
          tv_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.poll_req             = req_q;
  assign bus.poll_addr            = slot_q;
  assign total_percentage_stored  = r_q;
  assign number_of_stations       = g_q;
  assign no_stations              = nos_q;
  assign totals_valid             = tv_q;
  assign round_done               = rd_q;
  assign busy                     = busy_q;
endmodule
